cache_control: RTL and testbench

- Sequencing FSM for the 2-way set-associative L1 cache (8 sets, 16-byte lines, 9-bit tag = addr[15:7], index = addr[6:4]).
- Consumes the tag-compare result (hit, way_hit) and per-set status bits from the cache datapath.
- Drives array load enables, datapath mux selects, the CPU response and the physical-memory handshake.
- Handles read/write hits, clean-miss allocation, and dirty-victim writeback followed by allocation.

---
 rtl/lc3b_types.sv | 25 ++
 rtl/cache_control.sv | 122 ++++++++++++
 tb/tb_cache_control.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// ============================================================================
// lc3b_types : shared L1 cache geometry types and controller state encoding
// Revision   : 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

  localparam int C_TAG_W   = 9;
  localparam int C_INDEX_W = 3;
  localparam int C_LINE_W  = 128;

  typedef logic [C_TAG_W-1:0]   lc3b_tag;
  typedef logic [C_INDEX_W-1:0] lc3b_c_index;
  typedef logic [C_LINE_W-1:0]  lc3b_c_line;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } cache_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_control.sv
// ============================================================================
// cache_control : sequencing FSM for the 2-way set-associative L1 cache
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cache_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic way_hit,
  input  logic lru_out,
  input  logic valid0,
  input  logic valid1,
  input  logic dirty0,
  input  logic dirty1,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic pmem_addr_sel,
  output logic way_sel,
  output logic load_data,
  output logic load_tag,
  output logic load_valid,
  output logic load_dirty,
  output logic load_lru,
  output logic dirty_in,
  output logic lru_in,
  output logic datain_sel
);

  cache_state_t state;
  cache_state_t state_next;
  logic         victim;
  logic         request;
  logic         victim_dirty;

  assign request      = mem_read | mem_write;
  assign victim_dirty = lru_out ? (valid1 & dirty1) : (valid0 & dirty0);

  // The victim is latched once at miss detection and held for the whole miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      victim <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && request && !hit) begin
        victim <= lru_out;
      end
    end
  end

  always_comb begin
    state_next    = state;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    load_lru      = 1'b0;
    dirty_in      = 1'b0;
    lru_in        = 1'b0;
    datain_sel    = 1'b0;

    // Outputs stay quiet during reset so no array write can slip through.
    if (!reset) begin
      unique case (state)
        S_IDLE: begin
          if (request) begin
            if (hit) begin
              mem_resp = 1'b1;
              load_lru = 1'b1;
              lru_in   = ~way_hit;
              if (mem_write) begin
                way_sel    = way_hit;
                load_data  = 1'b1;
                load_dirty = 1'b1;
                dirty_in   = 1'b1;
              end
            end else begin
              state_next = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim;
          if (pmem_resp) begin
            state_next = S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel   = victim;
          if (pmem_resp) begin
            load_data  = 1'b1;
            datain_sel = 1'b1;
            load_tag   = 1'b1;
            load_valid = 1'b1;
            load_dirty = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: a per-cycle reference model plus
// hand-computed directed checks.
`default_nettype none

module tb_cache_control;

  logic clk = 1'b0;
  logic reset, mem_read, mem_write, hit, way_hit, lru_out;
  logic valid0, valid1, dirty0, dirty1, pmem_resp;
  logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel;
  logic load_data, load_tag, load_valid, load_dirty, load_lru;
  logic dirty_in, lru_in, datain_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .hit(hit), .way_hit(way_hit), .lru_out(lru_out),
    .valid0(valid0), .valid1(valid1), .dirty0(dirty0), .dirty1(dirty1),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
    .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .load_lru(load_lru), .dirty_in(dirty_in),
    .lru_in(lru_in), .datain_sel(datain_sel)
  );

  // Output bundle, MSB first:
  // mem_resp pmem_read pmem_write pmem_addr_sel way_sel load_data load_tag
  // load_valid load_dirty load_lru dirty_in lru_in datain_sel
  logic [12:0] dut_out;
  assign dut_out = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
                    load_data, load_tag, load_valid, load_dirty, load_lru,
                    dirty_in, lru_in, datain_sel};

  // Reference model: what the controller is doing for the CPU right now.
  bit busy_wb    = 0;  // writing the victim line back
  bit busy_fill  = 0;  // filling the victim way from memory
  bit miss_way   = 0;

  function automatic logic [12:0] model_out();
    logic [12:0] o;
    logic req, wr;
    o   = '0;
    req = mem_read | mem_write;
    wr  = mem_write;
    if (reset) return o;
    if (busy_wb) begin
      o[10] = 1'b1;           // pmem_write
      o[9]  = 1'b1;           // victim address
      o[8]  = miss_way;
    end else if (busy_fill) begin
      o[11] = 1'b1;           // pmem_read
      o[8]  = miss_way;
      if (pmem_resp) begin
        o[7] = 1'b1; o[6] = 1'b1; o[5] = 1'b1; o[4] = 1'b1; o[0] = 1'b1;
      end
    end else if (req && hit) begin
      o[12] = 1'b1;
      o[3]  = 1'b1;
      o[1]  = ~way_hit;
      if (wr) begin
        o[8] = way_hit; o[7] = 1'b1; o[4] = 1'b1; o[2] = 1'b1;
      end
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      busy_wb = 0; busy_fill = 0; miss_way = 0;
    end else if (busy_wb) begin
      if (pmem_resp) begin busy_wb = 0; busy_fill = 1; end
    end else if (busy_fill) begin
      if (pmem_resp) busy_fill = 0;
    end else if ((mem_read | mem_write) && !hit) begin
      miss_way = lru_out;
      if (lru_out ? (valid1 && dirty1) : (valid0 && dirty0)) busy_wb = 1;
      else busy_fill = 1;
    end
  end

  always @(negedge clk) begin
    logic [12:0] exp_o;
    exp_o = model_out();
    tests++;
    if (dut_out !== exp_o) begin
      fails++;
      $display("FAIL model_cmp t=%0t actual=%b required=%b", $time, dut_out, exp_o);
    end
    tests++;
    if (pmem_read === 1'b1 && pmem_write === 1'b1) begin
      fails++;
      $display("FAIL pmem_exclusive t=%0t actual=rd1_wr1 required=not_both", $time);
    end
    if (!reset && (busy_wb || busy_fill))
      assert (mem_read || mem_write) else $error("CPU dropped request mid-miss");
  end

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; mem_read = 0; mem_write = 0; hit = 0; way_hit = 0; lru_out = 0;
    valid0 = 0; valid1 = 0; dirty0 = 0; dirty1 = 0; pmem_resp = 0;
    tick(); tick();
    reset = 0;
    #2 chk("idle_quiet", dut_out, 13'd0);

    // Read miss on empty cache -> allocate, fill, then hit.
    mem_read = 1;
    tick();
    chk("alloc_pmem_read", pmem_read, 1);
    chk("alloc_addr_sel", pmem_addr_sel, 0);
    chk("alloc_no_load", load_data, 0);
    tick(); tick();
    pmem_resp = 1;
    #1;
    chk("fill_loads", {load_tag, load_valid, load_data, datain_sel}, 4'b1111);
    chk("fill_dirty_in", dirty_in, 0);
    tick();
    pmem_resp = 0; hit = 1; way_hit = 0;
    #1;
    chk("post_fill_hit", {mem_resp, load_lru, lru_in}, 3'b111);
    tick();

    // Write hit, way 1.
    mem_read = 0; mem_write = 1; hit = 1; way_hit = 1;
    #1;
    chk("whit_resp", mem_resp, 1);
    chk("whit_fields", {way_sel, load_data, datain_sel, load_dirty, dirty_in, lru_in},
        6'b110110);
    tick();

    // Dirty victim in way 0 -> writeback for 5 cycles, then allocate.
    mem_write = 0; mem_read = 1; hit = 0; lru_out = 0; valid0 = 1; dirty0 = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) pmem_resp = 1;
      #1;
      chk("wb_hold", {pmem_write, pmem_addr_sel, pmem_read}, 3'b110);
      tick();
    end
    pmem_resp = 0; lru_out = 1;
    #1;
    chk("wb_then_alloc", {pmem_read, pmem_write, way_sel}, 3'b100);
    tick();
    pmem_resp = 1;
    tick();
    pmem_resp = 0; hit = 1; way_hit = 0;
    tick();

    // Clean victim in way 1 -> direct allocate, victim held despite lru flip.
    mem_read = 0; mem_write = 1; hit = 0; lru_out = 1; valid1 = 1; dirty1 = 0;
    tick();
    chk("clean_alloc", {pmem_read, pmem_write, way_sel}, 3'b101);
    lru_out = 0;
    tick();
    chk("victim_held", way_sel, 1);
    pmem_resp = 1;
    #1;
    chk("fill_way1", {way_sel, load_data, datain_sel}, 3'b111);
    tick();
    pmem_resp = 0; hit = 1; way_hit = 1;
    tick();

    // Reset during allocate.
    mem_write = 0; mem_read = 1; hit = 0; lru_out = 0; dirty0 = 0;
    tick();
    chk("pre_reset_alloc", pmem_read, 1);
    reset = 1; mem_read = 0;
    #1;
    chk("reset_no_loads", {load_data, load_tag, load_valid, load_dirty, load_lru}, 5'd0);
    tick();
    reset = 0;
    #1;
    chk("after_reset_quiet", dut_out, 13'd0);
    tick();

    // Back-to-back hits alternating ways.
    mem_read = 1; hit = 1;
    for (int i = 0; i < 4; i++) begin
      way_hit = i[0];
      #1;
      chk("b2b_hit", {mem_resp, lru_in}, {1'b1, ~i[0]});
      tick();
    end
    mem_read = 0; hit = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
